updi_link_arbiter: RTL
======================

// Module: updi_link_arbiter
// PURPOSE
// Shares one updi_interface + double-break generator among N_REQ requesters (programmer
// FSM, debug poller, ...). Grants the link round-robin, one owner at a time, forwards only
// the owner's command/starts, tracks transaction completion, revokes hung owners.
// PARAMETERS
// N_REQ            2     number of requesters (2..8)
// XFER_TIMEOUT     4096  max clks a forwarded transaction may stay in flight
// HOLD_TIMEOUT     1024  max clks an owner may hold the grant with nothing in flight
// PORTS
// clk           in   1         clock
// rst           in   1         asynchronous active-low reset
// req           in   N_REQ     level: requester wants the link
// rel           in   N_REQ     pulse: owner releases the link
// req_cmd       in   N_REQ x updi_cmd_t  per-requester command (instr, sizes, ptr, cs_addr, sib, data, data_len, wait_ack_after, rx_n_bytes)
// req_tx_start  in   N_REQ     pulse: start TX of req_cmd
// req_rx_start  in   N_REQ     pulse: expect rx_n_bytes reply (same cycle as tx_start)
// req_db_start  in   N_REQ     pulse: request double break
// gnt           out  N_REQ     one-hot current owner
// own_done      out  N_REQ     pulse to owner: transaction complete
// own_ack_err   out  N_REQ     pulse to owner: if_ack_error seen during its transaction
// timeout       out  N_REQ     pulse: grant revoked by watchdog
// stray_err     out  1         pulse: start from a non-owner dropped
// if_cmd        out  updi_cmd_t  muxed owner command; 0 when no owner
// if_converter_en out 1        = forwarded tx_start
// if_tx_start / if_rx_start / db_start  out 1  forwarded owner pulses, combinational from owner
// if_tx_ready / if_rx_done / if_ack_error / db_done  in 1  from updi_interface / double break
// BEHAVIOUR
// - Reset (rst=0, async): state ARB_IDLE, gnt=0, all pulses 0, if_cmd=0, RR pointer -> index 0 highest.
// - States: ARB_IDLE, ARB_GRANT, ARB_BUSY, ARB_RELEASE.
// - IDLE: any req -> gnt registered next clk (1-clk latency), -> GRANT. Winner = first set req
//   at/after (last_owner+1) mod N_REQ; pointer updates on each grant.
// - GRANT: owner's tx_start/db_start forwarded same clk -> BUSY; rx_start latched as rx_pending.
//   rel or owner req=0 -> RELEASE. HOLD_TIMEOUT idle clks -> timeout[owner], RELEASE.
// - BUSY: first clk ignores if_tx_ready (handoff). Complete when TX: if_tx_ready=1 and
//   (rx_pending=0 or rx_done latched); DB: db_done=1. On complete own_done pulse, -> GRANT,
//   or RELEASE if rel/req-drop was latched during BUSY (release deferred, never mid-transfer).
//   if_ack_error in BUSY -> own_ack_err pulse, transaction continues to completion.
//   XFER_TIMEOUT clks -> timeout[owner], RELEASE (no own_done).
// - Further owner starts during BUSY: dropped, stray_err pulse.
// - RELEASE: gnt=0 for exactly 1 clk, -> IDLE; earliest next grant 2 clks after rel.
// - Non-owner starts in any state: dropped, stray_err=1 that clk; never forwarded.
// - rel from non-owner ignored silently. rel and tx_start same clk in GRANT: start wins,
//   release deferred to completion.
// - Counters XFER/HOLD saturate-free, width $clog2(max+1), cleared on every state entry.
// - gnt never has >1 bit set; gnt changes only via RELEASE.
// STRUCTURE
// - updi_pkg: updi_cmd_t packed struct, updi_arb_state_t enum, updi_instruction reuse.
// - Sub-module rr_arbiter (req, ptr -> one-hot winner), combinational, reusable.
// - Watchdog counter, mux and FSM inline.
// TESTING
// - Single req[0]: gnt=01 next clk; LDCS tx+rx 1 byte; own_done[0] after tx_ready & rx_done.
// - req=11 from reset: gnt=01; rel[0] -> gnt=00 1 clk -> gnt=10; then req=11 again -> 01.
// - Owner 0 rel during BUSY: gnt held until completion, own_done[0] then 1-clk gap.
// - req_tx_start[1] while gnt=01: not forwarded, stray_err=1, if_cmd unchanged.
// - XFER_TIMEOUT=16, if_tx_ready stuck 0: timeout[0] at clk 16 of BUSY, gnt drops, req[1] granted.
// - rst asserted mid-BUSY: gnt=0, outputs 0 immediately; after release req[1]-only grants 10.

Source files
------------

// File: rtl/updi_link_arbiter_pkg.sv
// rtl/updi_link_arbiter_pkg.sv - shared UPDI command, instruction and arbiter state types
package updi_link_arbiter_pkg;

    typedef enum logic [2:0] {
        UPDI_LDS    = 3'd0,
        UPDI_STS    = 3'd1,
        UPDI_LD     = 3'd2,
        UPDI_ST     = 3'd3,
        UPDI_LDCS   = 3'd4,
        UPDI_STCS   = 3'd5,
        UPDI_REPEAT = 3'd6,
        UPDI_KEY    = 3'd7
    } updi_instruction_t;

    typedef struct packed {
        updi_instruction_t instr;
        logic [1:0]        addr_size;
        logic [1:0]        data_size;
        logic [1:0]        ptr;
        logic [3:0]        cs_addr;
        logic              sib;
        logic [31:0]       data;
        logic [2:0]        data_len;
        logic              wait_ack_after;
        logic [3:0]        rx_n_bytes;
    } updi_cmd_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_BUSY    = 2'd2,
        ARB_RELEASE = 2'd3
    } updi_arb_state_t;

endpackage

// File: rtl/updi_link_arbiter_if.sv
// rtl/updi_link_arbiter_if.sv - requester and link-side signal bundle of the arbiter
interface updi_link_arbiter_if
    import updi_link_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            rel;
    updi_cmd_t [N_REQ-1:0]       req_cmd;
    logic [N_REQ-1:0]            req_tx_start;
    logic [N_REQ-1:0]            req_rx_start;
    logic [N_REQ-1:0]            req_db_start;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            own_done;
    logic [N_REQ-1:0]            own_ack_err;
    logic [N_REQ-1:0]            timeout;
    logic                        stray_err;
    updi_cmd_t                   if_cmd;
    logic                        if_converter_en;
    logic                        if_tx_start;
    logic                        if_rx_start;
    logic                        db_start;
    logic                        if_tx_ready;
    logic                        if_rx_done;
    logic                        if_ack_error;
    logic                        db_done;

    modport master (
        output req, rel, req_cmd, req_tx_start, req_rx_start, req_db_start,
               if_tx_ready, if_rx_done, if_ack_error, db_done,
        input  gnt, own_done, own_ack_err, timeout, stray_err,
               if_cmd, if_converter_en, if_tx_start, if_rx_start, db_start
    );

    modport slave (
        input  req, rel, req_cmd, req_tx_start, req_rx_start, req_db_start,
               if_tx_ready, if_rx_done, if_ack_error, db_done,
        output gnt, own_done, own_ack_err, timeout, stray_err,
               if_cmd, if_converter_en, if_tx_start, if_rx_start, db_start
    );
endinterface

// File: rtl/updi_link_arbiter_rr_arbiter.sv
// rtl/updi_link_arbiter_rr_arbiter.sv - combinational round-robin pick starting at index ptr
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);
    localparam logic [IW:0]      N_W = (IW + 1)'(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    logic [IW:0]      sum;

    // rotate so ptr lands at bit 0, then take the lowest set bit
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i[IW-1:0];
                any = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx   = sum[IW-1:0];
        grant = any ? (ONE << idx) : '0;
    end
endmodule

// File: rtl/updi_link_arbiter.sv
// rtl/updi_link_arbiter.sv - round-robin owner of one UPDI link with transaction tracking and watchdog
module updi_link_arbiter
    import updi_link_arbiter_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int XFER_TIMEOUT = 4096,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    updi_link_arbiter_if.slave bus
);
    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (XFER_TIMEOUT > HOLD_TIMEOUT) ? XFER_TIMEOUT : HOLD_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] XFER_LAST = CW'(XFER_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);

    updi_arb_state_t  state, state_next;
    logic [N_REQ-1:0] gnt, gnt_next;
    logic [IW-1:0]    owner, owner_next, ptr, ptr_next, ptr_adv;
    logic [CW-1:0]    cnt;
    logic             rx_pending, rx_pending_next, rx_seen, rx_seen_next;
    logic             rel_pending, rel_pending_next, xfer_db, xfer_db_next;
    logic [N_REQ-1:0] win_grant, done, ack, tmo;
    logic [IW-1:0]    win_idx;
    logic             win_any, owned, own_tx, own_rx, own_db, own_leave, complete;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign owned     = (state == ARB_GRANT) || (state == ARB_BUSY);
    assign own_tx    = |(bus.req_tx_start & gnt);
    assign own_rx    = |(bus.req_rx_start & gnt);
    assign own_db    = |(bus.req_db_start & gnt);
    assign own_leave = |(bus.rel & gnt) | ~|(bus.req & gnt);
    assign ptr_adv   = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign complete  = xfer_db ? bus.db_done
                     : ((cnt != '0) && bus.if_tx_ready && (!rx_pending || rx_seen || bus.if_rx_done));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            gnt         <= '0;
            owner       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            rx_pending  <= 1'b0;
            rx_seen     <= 1'b0;
            rel_pending <= 1'b0;
            xfer_db     <= 1'b0;
        end else begin
            state       <= state_next;
            gnt         <= gnt_next;
            owner       <= owner_next;
            ptr         <= ptr_next;
            cnt         <= (state_next != state) ? '0 : cnt + 1'b1;
            rx_pending  <= rx_pending_next;
            rx_seen     <= rx_seen_next;
            rel_pending <= rel_pending_next;
            xfer_db     <= xfer_db_next;
        end
    end

    always_comb begin
        state_next       = state;
        gnt_next         = gnt;
        owner_next       = owner;
        ptr_next         = ptr;
        rx_pending_next  = rx_pending;
        rx_seen_next     = rx_seen;
        rel_pending_next = rel_pending;
        xfer_db_next     = xfer_db;
        done             = '0;
        ack              = '0;
        tmo              = '0;
        bus.if_tx_start  = 1'b0;
        bus.if_rx_start  = 1'b0;
        bus.db_start     = 1'b0;
        case (state)
            // RELEASE already spent its one empty clk, so it may grant directly
            ARB_IDLE, ARB_RELEASE: begin
                if (win_any) begin
                    gnt_next   = win_grant;
                    owner_next = win_idx;
                    ptr_next   = ptr_adv;
                    state_next = ARB_GRANT;
                end else begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (own_tx || own_db) begin
                    bus.if_tx_start  = own_tx;
                    bus.if_rx_start  = own_tx & own_rx;
                    bus.db_start     = ~own_tx & own_db;
                    xfer_db_next     = ~own_tx;
                    rx_pending_next  = own_tx & own_rx;
                    rx_seen_next     = 1'b0;
                    rel_pending_next = own_leave;
                    state_next       = ARB_BUSY;
                end else if (own_leave) begin
                    gnt_next   = '0;
                    state_next = ARB_RELEASE;
                end else if (cnt == HOLD_LAST) begin
                    tmo        = gnt;
                    gnt_next   = '0;
                    state_next = ARB_RELEASE;
                end
            end
            ARB_BUSY: begin
                rel_pending_next = rel_pending | own_leave;
                rx_seen_next     = rx_seen | bus.if_rx_done;
                ack              = bus.if_ack_error ? gnt : '0;
                if (complete) begin
                    done = gnt;
                    if (rel_pending || own_leave) begin
                        gnt_next   = '0;
                        state_next = ARB_RELEASE;
                    end else begin
                        state_next = ARB_GRANT;
                    end
                end else if (cnt == XFER_LAST) begin
                    tmo        = gnt;
                    gnt_next   = '0;
                    state_next = ARB_RELEASE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // owner starts are legal only in GRANT; anything else is dropped and flagged
    assign bus.stray_err       = |((bus.req_tx_start | bus.req_db_start) & ~gnt)
                               | ((state == ARB_BUSY) & (own_tx | own_db));
    assign bus.gnt             = gnt;
    assign bus.own_done        = done;
    assign bus.own_ack_err     = ack;
    assign bus.timeout         = tmo;
    assign bus.if_converter_en = bus.if_tx_start;
    assign bus.if_cmd          = owned ? bus.req_cmd[owner] : '0;
endmodule
